// File: rtl/ace_vram_arbiter.sv
// Jupiter Ace screen-RAM arbiter: one synchronous 1 KB RAM shared by video scan-out
// and the Z80. Video has priority, last_grant alternates service when both wait.
module ace_vram_arbiter #(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter int          WIN_BITS  = 11,
    parameter int          AW        = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [15:0]   cpu_a,
    input  logic          cpu_mreq_n,
    input  logic          cpu_rd_n,
    input  logic          cpu_wr_n,
    input  logic [7:0]    cpu_do,
    output logic [7:0]    cpu_di,
    output logic          cpu_wait_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_ack,
    output logic [AW-1:0] ram_a,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout
);
    typedef enum logic [2:0] {IDLE, VID, VID_D, CPU, CPU_D} state_t;

    state_t        state, state_nx;
    logic          vpend, cpu_done, last_grant, cpu_wr_q;
    logic [AW-1:0] vaddr_q;
    logic          cpu_sel, cpu_req, grant_vid, grant_cpu;
    logic          unused_cpu_a;

    assign cpu_sel = ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n)
                   & (cpu_a[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]);
    assign cpu_req = cpu_sel & ~cpu_done;

    // Held released during reset so a frozen bus cannot lock the CPU.
    assign cpu_wait_n = ~reset_n | ~cpu_req;

    // Address bits between the RAM width and the window size only mirror.
    assign unused_cpu_a = ^cpu_a;

    assign grant_vid = (state == IDLE) && (state_nx == VID);
    assign grant_cpu = (state == IDLE) && (state_nx == CPU);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (vpend && cpu_req && last_grant) state_nx = CPU;
                else if (vpend)                     state_nx = VID;
                else if (cpu_req)                   state_nx = CPU;
            end
            VID:     state_nx = VID_D;
            VID_D:   state_nx = IDLE;
            CPU:     state_nx = CPU_D;
            CPU_D:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vpend      <= 1'b0;
            vaddr_q    <= '0;
            cpu_done   <= 1'b0;
            last_grant <= 1'b0;
            cpu_wr_q   <= 1'b0;
            vid_ack    <= 1'b0;
            vid_data   <= 8'h00;
            cpu_di     <= 8'h00;
            ram_a      <= '0;
            ram_we     <= 1'b0;
            ram_din    <= 8'h00;
        end else begin
            vid_ack <= 1'b0;

            // A request landing on the grant edge stays pending for the next IDLE.
            if (vid_req) begin
                vpend   <= 1'b1;
                vaddr_q <= vid_addr;
            end else if (grant_vid) begin
                vpend <= 1'b0;
            end

            if (!cpu_sel)            cpu_done <= 1'b0;
            else if (state == CPU_D) cpu_done <= 1'b1;

            case (state)
                IDLE: begin
                    if (grant_vid) begin
                        ram_a      <= vaddr_q;
                        ram_we     <= 1'b0;
                        last_grant <= 1'b1;
                    end else if (grant_cpu) begin
                        ram_a      <= cpu_a[AW-1:0];
                        ram_we     <= ~cpu_wr_n;
                        ram_din    <= cpu_do;
                        cpu_wr_q   <= ~cpu_wr_n;
                        last_grant <= 1'b0;
                    end
                end
                VID_D: begin
                    vid_data <= ram_dout;
                    vid_ack  <= 1'b1;
                end
                CPU: ram_we <= 1'b0;
                CPU_D: begin
                    if (!cpu_wr_q) cpu_di <= ram_dout;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ace_vram_arbiter.sv
// Directed bench for ace_vram_arbiter: stimulus queues expected video, CPU-read and
// RAM-write responses; negedge monitors pop and compare as the DUT presents them.
module tb_ace_vram_arbiter;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [15:0]   cpu_a = 16'h0000;
    logic          cpu_mreq_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
    logic [7:0]    cpu_do = 8'h00;
    logic [7:0]    cpu_di;
    logic          cpu_wait_n;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [7:0]    vid_data;
    logic          vid_ack;
    logic [AW-1:0] ram_a;
    logic          ram_we;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;

    typedef struct { logic [7:0] data; int req; int maxlat; bit exact; } vexp_t;
    typedef struct { logic [AW-1:0] a; logic [7:0] d; } wexp_t;

    vexp_t      vid_q[$];
    logic [7:0] cpu_q[$];
    wexp_t      wr_q[$];

    int   checks = 0, failures = 0, cyc = 0;
    bit   cpu_rd_busy = 1'b0;
    logic prev_wait = 1'b1;
    logic [7:0] mem [0:(1<<AW)-1];
    bit   mem_init = 1'b0;

    ace_vram_arbiter #(.BASE_ADDR(16'h2000), .WIN_BITS(11), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_mreq_n(cpu_mreq_n),
        .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_do(cpu_do), .cpu_di(cpu_di),
        .cpu_wait_n(cpu_wait_n), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_data(vid_data), .vid_ack(vid_ack), .ram_a(ram_a), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        case (a)
            10'h155: return 8'hA5;
            10'h001: return 8'h5A;
            10'h003: return 8'h22;
            10'h004: return 8'h44;
            10'h0AA: return 8'h11;
            10'h0AB: return 8'h33;
            10'h100: return 8'hC0;
            10'h101: return 8'hC1;
            10'h102: return 8'hC2;
            10'h103: return 8'hC3;
            10'h104: return 8'hC4;
            default: return 8'hEE;
        endcase
    endfunction

    // Synchronous RAM model: read data one clock after the address edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(AW'(i));
            mem_init <= 1'b1;
        end else if (ram_we) begin
            mem[ram_a] <= ram_din;
        end
        ram_dout <= mem[ram_a];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            failures++;
            $display("FAIL %s: got %0d limit %0d", name, act, lim);
        end
    endtask

    always @(negedge clk) begin : vid_mon
        vexp_t e;
        if (vid_ack) begin
            if (vid_q.size() == 0) begin
                chk("vid_ack_spurious", 32'(vid_ack), 32'd0);
            end else begin
                e = vid_q.pop_front();
                chk("vid_data", 32'(vid_data), 32'(e.data));
                if (e.exact) chk("vid_latency", 32'(cyc - e.req), 32'(e.maxlat));
                else         chk_le("vid_latency_max", cyc - e.req, e.maxlat);
            end
        end
    end

    always @(negedge clk) begin : cpu_mon
        if (cpu_rd_busy && !prev_wait && cpu_wait_n) begin
            if (cpu_q.size() == 0) chk("cpu_rd_spurious", 32'(cpu_wait_n), 32'd0);
            else                   chk("cpu_di", 32'(cpu_di), 32'(cpu_q.pop_front()));
        end
        prev_wait = cpu_wait_n;
    end

    always @(negedge clk) begin : wr_mon
        wexp_t w;
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                chk("ram_we_spurious", 32'(ram_we), 32'd0);
            end else begin
                w = wr_q.pop_front();
                chk("wr_ram_a", 32'(ram_a), 32'(w.a));
                chk("wr_ram_din", 32'(ram_din), 32'(w.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n = number of rising edges until cpu_wait_n is seen released.
    task automatic cpu_op(input logic [15:0] a, input bit wr, input logic [7:0] d, output int n);
        cpu_a = a;
        cpu_do = d;
        cpu_mreq_n = 1'b0;
        if (wr) cpu_wr_n = 1'b0;
        else begin
            cpu_rd_n = 1'b0;
            cpu_rd_busy = 1'b1;
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (cpu_wait_n) break;
        end
        @(negedge clk);
        #1;
        cpu_mreq_n = 1'b1;
        cpu_rd_n = 1'b1;
        cpu_wr_n = 1'b1;
        cpu_rd_busy = 1'b0;
        tick();
    endtask

    task automatic vid_pulse(input logic [AW-1:0] a, input logic [7:0] d, input int maxlat,
                             input bit exact, input bit expect_ack);
        vexp_t e;
        vid_req = 1'b1;
        vid_addr = a;
        if (expect_ack) begin
            e.data = d;
            e.req = cyc + 1;
            e.maxlat = maxlat;
            e.exact = exact;
            vid_q.push_back(e);
        end
        tick();
        vid_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int    n;
        wexp_t w;

        // Reset state, with an in-window access held to show wait stays released.
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_vid_ack", 32'(vid_ack), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_a", 32'(ram_a), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_cpu_di", 32'(cpu_di), 32'd0);
        chk("rst_vid_data", 32'(vid_data), 32'd0);
        cpu_a = 16'h2000;
        cpu_mreq_n = 1'b0;
        cpu_rd_n = 1'b0;
        #1;
        chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        cpu_mreq_n = 1'b1;
        cpu_rd_n = 1'b1;
        tick();
        reset_n = 1'b1;

        // Idle video fetch: 3-clock latency, ram_a after edge 1, no CPU stall.
        vid_pulse(10'h155, 8'hA5, 3, 1'b1, 1'b1);
        tick();
        chk("vid_ram_a", 32'(ram_a), 32'h155);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("vid_wait_n", 32'(cpu_wait_n), 32'd1);
        end

        // CPU write through a mirror, then read it back.
        w.a = 10'h010;
        w.d = 8'h3C;
        wr_q.push_back(w);
        cpu_op(16'h2410, 1'b1, 8'h3C, n);
        chk("wr_wait_edges", 32'(n), 32'd3);
        cpu_q.push_back(8'h3C);
        cpu_op(16'h2010, 1'b0, 8'h00, n);
        chk("rd_wait_edges", 32'(n), 32'd3);

        // Out-of-window read: no wait, RAM untouched.
        cpu_a = 16'h3000;
        cpu_mreq_n = 1'b0;
        cpu_rd_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("oow_wait_n", 32'(cpu_wait_n), 32'd1);
            chk("oow_ram_we", 32'(ram_we), 32'd0);
            chk("oow_ram_a", 32'(ram_a), 32'h010);
        end
        cpu_mreq_n = 1'b1;
        cpu_rd_n = 1'b1;
        tick();

        // Video stream every 3 clocks against a CPU read.
        cpu_q.push_back(8'h5A);
        fork
            cpu_op(16'h2001, 1'b0, 8'h00, n);
            begin
                for (int k = 0; k < 5; k++) begin
                    vid_pulse(AW'(10'h100 + k), 8'(8'hC0 + k), 5, 1'b0, 1'b1);
                    if (k < 4) repeat (2) tick();
                end
            end
        join
        chk_le("stream_cpu_edges", n, 6);
        repeat (8) tick();

        // After reset (last_grant=0): both pending -> video, then CPU, twice.
        do_reset();
        vid_pulse(10'h0AA, 8'h11, 3, 1'b1, 1'b1);
        cpu_q.push_back(8'h22);
        cpu_op(16'h2003, 1'b0, 8'h00, n);
        chk("pair1_cpu_edges", 32'(n), 32'd6);
        vid_pulse(10'h0AB, 8'h33, 3, 1'b1, 1'b1);
        cpu_q.push_back(8'h44);
        cpu_op(16'h2004, 1'b0, 8'h00, n);
        chk("pair2_cpu_edges", 32'(n), 32'd6);
        repeat (2) tick();

        // Reset in the CPU state of a write, with a video request pending.
        do_reset();
        w.a = 10'h050;
        w.d = 8'h77;
        wr_q.push_back(w);
        cpu_a = 16'h2050;
        cpu_do = 8'h77;
        cpu_mreq_n = 1'b0;
        cpu_wr_n = 1'b0;
        vid_pulse(10'h0AC, 8'h00, 0, 1'b0, 1'b0);
        chk("mid_we_before", 32'(ram_we), 32'd1);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
        chk("mid_rst_wait_n", 32'(cpu_wait_n), 32'd1);
        chk("mid_rst_ram_a", 32'(ram_a), 32'd0);
        chk("mid_rst_vid_ack", 32'(vid_ack), 32'd0);
        cpu_mreq_n = 1'b1;
        cpu_wr_n = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_vid_ack", 32'(vid_ack), 32'd0);
            chk("post_rst_ram_we", 32'(ram_we), 32'd0);
        end

        chk("vid_q_empty", 32'(vid_q.size()), 32'd0);
        chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ace_vram_arbiter.md
# ace_vram_arbiter

Single-port screen-RAM arbiter for the Jupiter Ace core, sitting between the negative-edge Z80 bus wrapper, the video scan-out and one synchronous 1 KB video RAM. Video fetches have priority, but a fairness rule keeps the CPU from starving. A CPU access that falls in the VRAM window is stretched by holding `cpu_wait_n` low until the RAM operation completes. Everything runs in one clock domain.

## Interface
- `BASE_ADDR`, 16'h2000: base of the CPU VRAM window.
- `WIN_BITS`, 11: log2 of the window size. `cpu_a[15:WIN_BITS]` is compared with `BASE_ADDR[15:WIN_BITS]`.
- `AW`, 10: RAM address width. The RAM is mirrored across the window through `cpu_a[AW-1:0]`.
- `clk` in 1: system clock. All state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `cpu_a` in 16: CPU address.
- `cpu_mreq_n`, `cpu_rd_n`, `cpu_wr_n` in 1 each: CPU strobes, driven from negedge flops.
- `cpu_do` in 8: CPU write data.
- `cpu_di` out 8: CPU read data.
- `cpu_wait_n` out 1: CPU wait; low stalls the CPU.
- `vid_req` in 1: single-cycle video fetch request.
- `vid_addr` in AW: video fetch address, sampled together with `vid_req`.
- `vid_data` out 8: fetched byte.
- `vid_ack` out 1: one-cycle pulse; `vid_data` is valid in the same cycle.
- `ram_a` out AW: RAM address.
- `ram_we` out 1: RAM write enable.
- `ram_din` out 8: RAM write data.
- `ram_dout` in 8: RAM read data, valid one clock after the address edge.

## Operation
- `cpu_sel` = `~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n) & (cpu_a[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS])`.
- `cpu_done` flag:
  - set when a CPU operation finishes;
  - cleared in any cycle where `cpu_sel` = 0;
  - one bus cycle therefore produces exactly one RAM operation.
- `cpu_wait_n` = `~(cpu_sel & ~cpu_done)`. This is combinational, and is forced to 1 while `reset_n` = 0.
- Video pending flag `vpend`:
  - set, and `vid_addr` captured into `vaddr_q`, on the edge where `vid_req` = 1;
  - cleared when the video operation enters VID.
  - A new `vid_req` while `vpend` = 1 is a protocol violation: the latest address wins and one `vid_ack` is produced.
- States: IDLE, VID, VID_D, CPU, CPU_D. The `last_grant` bit records who was served last (0 = CPU, 1 = video).
- Arbitration in IDLE (`cpu_req` = `cpu_sel & ~cpu_done`):
  - `vpend` & `cpu_req` & `last_grant` = 1 → CPU;
  - else `vpend` → VID;
  - else `cpu_req` → CPU;
  - else stay in IDLE.
- IDLE → VID: `ram_a` <= `vaddr_q`, `ram_we` <= 0, `last_grant` <= 1.
- VID → VID_D: unconditional.
- VID_D → IDLE: `vid_data` <= `ram_dout`, `vid_ack` <= 1 for one cycle.
- IDLE → CPU:
  - `ram_a` <= `cpu_a[AW-1:0]`, `ram_we` <= `~cpu_wr_n`, `ram_din` <= `cpu_do`, `last_grant` <= 0.
  - A write is detected only from `cpu_wr_n` low.
- CPU → CPU_D: `ram_we` <= 0, so a write pulse lasts exactly one clock.
- CPU_D → IDLE: `cpu_done` <= 1; for a read, `cpu_di` <= `ram_dout`. `cpu_di` holds its value until the next CPU read completes.
- Out-of-window CPU accesses never touch the RAM and never assert wait.
- Reset (also mid-operation), values on the reset edge:
  - state IDLE, `vpend` 0, `cpu_done` 0, `last_grant` 0;
  - `vid_ack` 0, `ram_we` 0, `ram_a` 0, `ram_din` 0, `cpu_di` 0x00, `vid_data` 0x00.
  - Any in-flight operation is abandoned with no ack.

## Timing
- Video latency when idle: `vid_req` is sampled at edge 0 and `vid_ack` is high for the cycle after edge 3 (3 clocks).
- Worst-case video latency is 5 clocks: a CPU grant just taken, plus 2 clocks of CPU_D/IDLE overlap.
- CPU access, idle block: `cpu_sel` is first high at edge e; the state is CPU after e and CPU_D after e+1; `cpu_done` is set at e+2.
  - `cpu_wait_n` is low from `cpu_sel` rising until edge e+2 (about 2 clocks).
  - For a read, `cpu_di` is valid from e+2.
- When a video request and a CPU request meet in IDLE, they alternate by `last_grant`. Neither requester waits more than one opposing operation (3 clocks) beyond its own latency.
- Simultaneous `vid_req` and grant decision: a `vid_req` sampled on the same edge as an IDLE decision is not seen until the next IDLE.
- The RAM is never driven by two operations in one cycle; `ram_we` is only ever high in the CPU state.

## Test plan
- Reset, then `vid_req` with `vid_addr`=0x155 and RAM[0x155]=0xA5 → `ram_a`=0x155 after edge 1, `vid_ack`=1 and `vid_data`=0xA5 exactly 3 clocks after the request; `cpu_wait_n` stays 1.
- CPU write 0x3C to 0x2410 → exactly one clock with `ram_we`=1, `ram_a`=0x010, `ram_din`=0x3C. Then a CPU read of 0x2010 → `cpu_di`=0x3C, with `cpu_wait_n` low for 2 clocks.
- CPU read of 0x3000 (outside the window) → `cpu_wait_n` constant 1, no change on `ram_a` or `ram_we`.
- `vid_req` every 3 clocks while the CPU holds a read at 0x2001 → the CPU is granted after at most one video operation, every `vid_ack` arrives within 5 clocks, and no `vid_req` is lost.
- CPU and video requests arrive on the same edge after reset (`last_grant`=0) → video served first and the CPU next; the order then alternates.
- `reset_n` pulled low in the CPU state during a write → `ram_we`=0 on the reset edge, `cpu_wait_n`=1 during reset, state IDLE, and no `vid_ack` afterwards.
